// File: rtl/textlcd_rx_if.sv
// HD44780-style 8-bit text-LCD bus: E/RS/RW/DATA from the writer, read-back data to it.
interface textlcd_rx_if;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;

  modport master (
    output lcd_e, lcd_rs, lcd_rw, lcd_data_in,
    input  lcd_data_out, lcd_data_oe
  );

  modport slave (
    input  lcd_e, lcd_rs, lcd_rw, lcd_data_in,
    output lcd_data_out, lcd_data_oe
  );
endinterface

// File: rtl/textlcd_rx.sv
// Responder end of a text-LCD bus: samples E-fall transactions, decodes instructions,
// mirrors the 2x16 character buffer and answers read cycles.
module textlcd_rx #(
  parameter int BUSY_CYC = 4,
  parameter int CLR_CYC  = 40
) (
  input  logic        clk,
  input  logic        resetn,
  textlcd_rx_if.slave bus,
  input  logic [4:0]  rd_addr,
  output logic [7:0]  rd_char,
  output logic [6:0]  addr_cnt,
  output logic        disp_on,
  output logic        cursor_on,
  output logic        blink_on,
  output logic        two_line,
  output logic        busy,
  output logic        cmd_strobe,
  output logic        data_strobe,
  output logic        overrun
);
  localparam int         CNT_W = $clog2(CLR_CYC + 1);
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up);
    if (up) begin
      if (ac == 7'h27) return 7'h40;
      if (ac == 7'h67) return 7'h00;
      return ac + 7'd1;
    end
    if (ac == 7'h00) return 7'h67;
    if (ac == 7'h40) return 7'h27;
    return ac - 7'd1;
  endfunction

  function automatic logic ac_mapped(input logic [6:0] ac);
    return (ac[6:4] == 3'b000) || (ac[6:4] == 3'b100);
  endfunction

  // 0x00-0x0F -> 0-15, 0x40-0x4F -> 16-31
  function automatic logic [4:0] ac_index(input logic [6:0] ac);
    return {ac[6], ac[3:0]};
  endfunction

  logic [10:0]      sync_p0, sync_p1, word_p2;
  logic             e_p1, rs_p1, rw_p1;
  logic             vld_p2, rs_p2, rw_p2;
  logic [7:0]       d_p2;
  logic [CNT_W-1:0] busy_cnt;
  logic [6:0]       ac;
  logic             inc;
  logic [7:0]       mem [32];
  logic [7:0]       rd_val;
  state_t           state_q, state_d;
  logic [4:0]       clr_idx;
  logic             fill_we;
  logic             wr_p2, can_accept, accept, cmd_acc, dat_acc, rd_dat_p2;
  logic             clr_start, home;

  // Stage p0/p1: E, RS, RW and data share one synchronizer so the word stays aligned with E
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      word_p2 <= '0;
    end else begin
      sync_p0 <= {bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_data_in};
      sync_p1 <= sync_p0;
      word_p2 <= sync_p1;
    end
  end

  assign e_p1  = sync_p1[10];
  assign rs_p1 = sync_p1[9];
  assign rw_p1 = sync_p1[8];

  // Stage p2: word_p2 holds the last word seen with E high; vld marks the E fall
  assign vld_p2 = word_p2[10] & ~e_p1;
  assign rs_p2  = word_p2[9];
  assign rw_p2  = word_p2[8];
  assign d_p2   = word_p2[7:0];

  // A counter on its final busy clock still lets the transaction in
  assign wr_p2      = vld_p2 & ~rw_p2;
  assign can_accept = (busy_cnt <= CNT_W'(1));
  assign accept     = wr_p2 & can_accept;
  assign cmd_acc    = accept & ~rs_p2;
  assign dat_acc    = accept & rs_p2;
  assign rd_dat_p2  = vld_p2 & rw_p2 & rs_p2;
  assign clr_start  = cmd_acc & (d_p2 == 8'h01);
  assign home       = cmd_acc & (d_p2[7:1] == 7'b0000001);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ac          <= '0;
      inc         <= 1'b1;
      disp_on     <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      two_line    <= 1'b0;
      busy_cnt    <= '0;
      cmd_strobe  <= 1'b0;
      data_strobe <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      cmd_strobe  <= cmd_acc;
      data_strobe <= dat_acc;
      if (wr_p2 && !can_accept) overrun <= 1'b1;
      if (accept)
        busy_cnt <= (clr_start || home) ? CNT_W'(CLR_CYC) : CNT_W'(BUSY_CYC);
      else if (busy_cnt != '0)
        busy_cnt <= busy_cnt - CNT_W'(1);
      if (dat_acc || rd_dat_p2) ac <= ac_step(ac, inc);
      if (cmd_acc) begin
        casez (d_p2)
          8'b1???????: ac <= d_p2[6:0];
          8'b01??????: ;
          8'b001?????: two_line <= d_p2[3];
          8'b0001????: if (!d_p2[3]) ac <= ac_step(ac, d_p2[2]);
          8'b00001???: begin
            disp_on   <= d_p2[2];
            cursor_on <= d_p2[1];
            blink_on  <= d_p2[0];
          end
          8'b000001??: inc <= d_p2[1];
          8'b0000001?: ac <= '0;
          8'b00000001: begin
            ac  <= '0;
            inc <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Clear sequencer: sweeps the buffer one location per clock
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      clr_idx <= '0;
    end else begin
      state_q <= state_d;
      clr_idx <= (state_q == ST_CLEAR) ? clr_idx + 5'd1 : 5'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clr_start) state_d = ST_CLEAR;
      ST_CLEAR: if (clr_idx == 5'd31) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fill_we = (state_q == ST_CLEAR);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) mem[i] <= SPACE;
    end else begin
      if (fill_we) mem[clr_idx] <= SPACE;
      if (dat_acc && ac_mapped(ac)) mem[ac_index(ac)] <= d_p2;
    end
  end

  always_comb begin
    rd_val = {busy, ac};
    if (rs_p1) rd_val = ac_mapped(ac) ? mem[ac_index(ac)] : SPACE;
  end

  // Read-back stage: driven only while the synced E is high on a read cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.lcd_data_oe  <= 1'b0;
      bus.lcd_data_out <= '0;
    end else begin
      bus.lcd_data_oe  <= e_p1 & rw_p1;
      bus.lcd_data_out <= (e_p1 & rw_p1) ? rd_val : 8'h00;
    end
  end

  assign busy     = (busy_cnt != '0);
  assign addr_cnt = ac;
  assign rd_char  = mem[rd_addr];
endmodule

// File: tb/tb_textlcd_rx.sv
// Directed bench for textlcd_rx: bus writes/reads with hand-computed buffer, AC and flag values.
module tb_textlcd_rx;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] rd_addr = '0;
  logic [7:0] rd_char;
  logic [6:0] addr_cnt;
  logic       disp_on, cursor_on, blink_on, two_line, busy;
  logic       cmd_strobe, data_strobe, overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cmd_seen = 0;
  int dat_seen = 0;

  textlcd_rx_if bus ();

  textlcd_rx #(.BUSY_CYC(4), .CLR_CYC(40)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .rd_addr     (rd_addr),
    .rd_char     (rd_char),
    .addr_cnt    (addr_cnt),
    .disp_on     (disp_on),
    .cursor_on   (cursor_on),
    .blink_on    (blink_on),
    .two_line    (two_line),
    .busy        (busy),
    .cmd_strobe  (cmd_strobe),
    .data_strobe (data_strobe),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_strobe)  cmd_seen++;
    if (data_strobe) dat_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(posedge clk); #2;
    bus.lcd_rs = rs; bus.lcd_rw = 1'b0; bus.lcd_data_in = d; bus.lcd_e = 1'b1;
    repeat (4) @(posedge clk); #2;
    bus.lcd_e = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] val, output logic oe);
    @(posedge clk); #2;
    bus.lcd_rs = rs; bus.lcd_rw = 1'b1; bus.lcd_e = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    val = bus.lcd_data_out;
    oe  = bus.lcd_data_oe;
    @(posedge clk); #2;
    bus.lcd_e = 1'b0;
    repeat (8) @(posedge clk); #2;
    bus.lcd_rw = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_timeout: busy=%b after %0d cycles, want 0", busy, limit);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      rd_addr = i[4:0]; #1;
      n_cmp++;
      if (rd_char !== 8'h20) begin n_bad++; $display("FAIL reset_buf[%0d]: got %h want 20", i, rd_char); end
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++;
    if (addr_cnt !== 7'h00) begin n_bad++; $display("FAIL reset_ac: got %h want 00", addr_cnt); end
    n_cmp++;
    if ({disp_on, cursor_on, blink_on, two_line} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {disp_on, cursor_on, blink_on, two_line});
    end
    n_cmp++;
    if ({cmd_strobe, data_strobe, overrun} !== 3'b000) begin
      n_bad++; $display("FAIL reset_strobes: got %b want 000", {cmd_strobe, data_strobe, overrun});
    end
    n_cmp++;
    if ({bus.lcd_data_oe, bus.lcd_data_out} !== 9'h000) begin
      n_bad++; $display("FAIL reset_rdout: got %h want 000", {bus.lcd_data_oe, bus.lcd_data_out});
    end
  endtask

  task automatic test_init_text();
    logic [7:0] txt [6] = '{8'h49, 8'h4E, 8'h53, 8'h45, 8'h52, 8'h54};
    int c0 = cmd_seen;
    int d0 = dat_seen;
    bus_write(1'b0, 8'h3C);
    bus_write(1'b0, 8'h0C);
    bus_write(1'b0, 8'h06);
    for (int i = 0; i < 6; i++) bus_write(1'b1, txt[i]);
    for (int i = 0; i < 6; i++) begin
      rd_addr = i[4:0]; #1;
      n_cmp++;
      if (rd_char !== txt[i]) begin n_bad++; $display("FAIL text_buf[%0d]: got %h want %h", i, rd_char, txt[i]); end
    end
    rd_addr = 5'd6; #1;
    n_cmp++;
    if (rd_char !== 8'h20) begin n_bad++; $display("FAIL text_buf[6]: got %h want 20", rd_char); end
    n_cmp++;
    if (addr_cnt !== 7'h06) begin n_bad++; $display("FAIL text_ac: got %h want 06", addr_cnt); end
    n_cmp++;
    if ({disp_on, cursor_on, blink_on} !== 3'b100) begin
      n_bad++; $display("FAIL text_dcb: got %b want 100", {disp_on, cursor_on, blink_on});
    end
    n_cmp++;
    if (two_line !== 1'b1) begin n_bad++; $display("FAIL text_two_line: got %b want 1", two_line); end
    n_cmp++;
    if (cmd_seen - c0 !== 3) begin n_bad++; $display("FAIL text_cmd_strobes: got %0d want 3", cmd_seen - c0); end
    n_cmp++;
    if (dat_seen - d0 !== 6) begin n_bad++; $display("FAIL text_data_strobes: got %0d want 6", dat_seen - d0); end
    n_cmp++;
    if (overrun !== 1'b0) begin n_bad++; $display("FAIL text_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_line2_wrap();
    int d0;
    bus_write(1'b0, 8'hC0);
    bus_write(1'b1, 8'h41);
    rd_addr = 5'd16; #1;
    n_cmp++;
    if (rd_char !== 8'h41) begin n_bad++; $display("FAIL line2_buf16: got %h want 41", rd_char); end
    n_cmp++;
    if (addr_cnt !== 7'h41) begin n_bad++; $display("FAIL line2_ac: got %h want 41", addr_cnt); end
    bus_write(1'b0, 8'hA7);
    n_cmp++;
    if (addr_cnt !== 7'h27) begin n_bad++; $display("FAIL set_ac27: got %h want 27", addr_cnt); end
    d0 = dat_seen;
    bus_write(1'b1, 8'h5A);
    n_cmp++;
    if (addr_cnt !== 7'h40) begin n_bad++; $display("FAIL wrap_27_40: got %h want 40", addr_cnt); end
    rd_addr = 5'd16; #1;
    n_cmp++;
    if (rd_char !== 8'h41) begin n_bad++; $display("FAIL unmapped_store: buf16 got %h want 41", rd_char); end
    n_cmp++;
    if (dat_seen - d0 !== 1) begin n_bad++; $display("FAIL unmapped_strobe: got %0d want 1", dat_seen - d0); end
    bus_write(1'b0, 8'h10);
    n_cmp++;
    if (addr_cnt !== 7'h27) begin n_bad++; $display("FAIL shift_dec_40_27: got %h want 27", addr_cnt); end
    bus_write(1'b0, 8'h04);
    bus_write(1'b0, 8'h80);
    bus_write(1'b1, 8'h44);
    rd_addr = 5'd0; #1;
    n_cmp++;
    if (rd_char !== 8'h44) begin n_bad++; $display("FAIL dec_store: buf0 got %h want 44", rd_char); end
    n_cmp++;
    if (addr_cnt !== 7'h67) begin n_bad++; $display("FAIL dec_wrap_00_67: got %h want 67", addr_cnt); end
    bus_write(1'b0, 8'h14);
    n_cmp++;
    if (addr_cnt !== 7'h00) begin n_bad++; $display("FAIL shift_inc_67_00: got %h want 00", addr_cnt); end
    bus_write(1'b0, 8'h10);
    n_cmp++;
    if (addr_cnt !== 7'h67) begin n_bad++; $display("FAIL shift_dec_00_67: got %h want 67", addr_cnt); end
    bus_write(1'b0, 8'h14);
    bus_write(1'b0, 8'h18);
    n_cmp++;
    if (addr_cnt !== 7'h00) begin n_bad++; $display("FAIL display_shift_ac: got %h want 00", addr_cnt); end
    bus_write(1'b0, 8'h06);
  endtask

  task automatic test_clear();
    logic [7:0] v;
    logic       oe;
    int c0 = cmd_seen;
    int d0 = dat_seen;
    bus_write(1'b0, 8'h0B);
    bus_write(1'b0, 8'h01);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL clear_busy: got %b want 1", busy); end
    bus_write(1'b1, 8'h51);
    n_cmp++;
    if (overrun !== 1'b1) begin n_bad++; $display("FAIL clear_overrun: got %b want 1", overrun); end
    n_cmp++;
    if (dat_seen !== d0) begin n_bad++; $display("FAIL clear_dropped: data strobes got %0d want %0d", dat_seen, d0); end
    bus_read(1'b0, v, oe);
    n_cmp++;
    if (oe !== 1'b1) begin n_bad++; $display("FAIL status_oe: got %b want 1", oe); end
    n_cmp++;
    if (v !== 8'h80) begin n_bad++; $display("FAIL status_read: got %h want 80", v); end
    wait_idle(200);
    n_cmp++;
    if (cmd_seen - c0 !== 2) begin n_bad++; $display("FAIL clear_cmd_strobes: got %0d want 2", cmd_seen - c0); end
    for (int i = 0; i < 32; i++) begin
      rd_addr = i[4:0]; #1;
      n_cmp++;
      if (rd_char !== 8'h20) begin n_bad++; $display("FAIL clear_buf[%0d]: got %h want 20", i, rd_char); end
    end
    n_cmp++;
    if (addr_cnt !== 7'h00) begin n_bad++; $display("FAIL clear_ac: got %h want 00", addr_cnt); end
    n_cmp++;
    if ({disp_on, cursor_on, blink_on} !== 3'b011) begin
      n_bad++; $display("FAIL clear_keeps_dcb: got %b want 011", {disp_on, cursor_on, blink_on});
    end
  endtask

  task automatic test_read_data();
    logic [7:0] v;
    logic       oe;
    int c0, d0;
    bus_write(1'b1, 8'h58);
    rd_addr = 5'd0; #1;
    n_cmp++;
    if (rd_char !== 8'h58) begin n_bad++; $display("FAIL rd_setup_buf0: got %h want 58", rd_char); end
    bus_write(1'b0, 8'h80);
    c0 = cmd_seen;
    d0 = dat_seen;
    bus_read(1'b1, v, oe);
    n_cmp++;
    if ({oe, v} !== 9'h158) begin n_bad++; $display("FAIL data_read: got oe=%b %h want oe=1 58", oe, v); end
    n_cmp++;
    if (addr_cnt !== 7'h01) begin n_bad++; $display("FAIL data_read_ac: got %h want 01", addr_cnt); end
    n_cmp++;
    if ((cmd_seen != c0) || (dat_seen != d0) || busy) begin
      n_bad++; $display("FAIL data_read_side: cmd +%0d data +%0d busy %b want 0 0 0", cmd_seen - c0, dat_seen - d0, busy);
    end
    n_cmp++;
    if ({bus.lcd_data_oe, bus.lcd_data_out} !== 9'h000) begin
      n_bad++; $display("FAIL read_release: got %h want 000", {bus.lcd_data_oe, bus.lcd_data_out});
    end
    bus_write(1'b0, 8'h90);
    bus_read(1'b1, v, oe);
    n_cmp++;
    if (v !== 8'h20) begin n_bad++; $display("FAIL unmapped_read: got %h want 20", v); end
    n_cmp++;
    if (addr_cnt !== 7'h11) begin n_bad++; $display("FAIL unmapped_read_ac: got %h want 11", addr_cnt); end
  endtask

  task automatic test_back_to_back();
    int c0, d0;
    bus_write(1'b0, 8'h80);
    c0 = cmd_seen;
    d0 = dat_seen;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      bus.lcd_rs = 1'b1; bus.lcd_rw = 1'b0; bus.lcd_data_in = 8'h30 + 8'(i); bus.lcd_e = 1'b1;
      repeat (4) @(posedge clk); #2;
      bus.lcd_e = 1'b0;
      repeat (3) @(posedge clk);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (dat_seen - d0 !== 8) begin n_bad++; $display("FAIL b2b_data_strobes: got %0d want 8", dat_seen - d0); end
    n_cmp++;
    if (cmd_seen !== c0) begin n_bad++; $display("FAIL b2b_cmd_strobes: got %0d want %0d", cmd_seen, c0); end
    for (int i = 0; i < 8; i++) begin
      rd_addr = i[4:0]; #1;
      n_cmp++;
      if (rd_char !== 8'h30 + 8'(i)) begin n_bad++; $display("FAIL b2b_buf[%0d]: got %h want %h", i, rd_char, 8'h30 + 8'(i)); end
    end
    n_cmp++;
    if (addr_cnt !== 7'h08) begin n_bad++; $display("FAIL b2b_ac: got %h want 08", addr_cnt); end
  endtask

  task automatic test_reset_mid_clear();
    bus_write(1'b0, 8'h0F);
    bus_write(1'b0, 8'h01);
    resetn = 1'b0;
    #3;
    n_cmp++;
    if ({busy, overrun} !== 2'b00) begin n_bad++; $display("FAIL async_reset: busy,overrun got %b want 00", {busy, overrun}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({disp_on, cursor_on, blink_on, two_line} !== 4'b0000) begin
      n_bad++; $display("FAIL midclr_flags: got %b want 0000", {disp_on, cursor_on, blink_on, two_line});
    end
    n_cmp++;
    if ({busy, addr_cnt} !== 8'h00) begin n_bad++; $display("FAIL midclr_busy_ac: got %h want 00", {busy, addr_cnt}); end
    for (int i = 0; i < 32; i++) begin
      rd_addr = i[4:0]; #1;
      n_cmp++;
      if (rd_char !== 8'h20) begin n_bad++; $display("FAIL midclr_buf[%0d]: got %h want 20", i, rd_char); end
    end
    bus_write(1'b1, 8'h4B);
    rd_addr = 5'd0; #1;
    n_cmp++;
    if (rd_char !== 8'h4B) begin n_bad++; $display("FAIL post_reset_write: got %h want 4B", rd_char); end
    n_cmp++;
    if ({overrun, addr_cnt} !== 8'h01) begin n_bad++; $display("FAIL post_reset_ac: got %h want 01", {overrun, addr_cnt}); end
  endtask

  initial begin
    bus.lcd_e = 1'b0;
    bus.lcd_rs = 1'b0;
    bus.lcd_rw = 1'b0;
    bus.lcd_data_in = 8'h00;
    test_reset();
    test_init_text();
    test_line2_wrap();
    test_clear();
    test_read_data();
    test_back_to_back();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
